horner_poly_evaluator: RTL
==========================

Name: horner_poly_evaluator

Overview:
- Evaluates y = c[0] + c[1]·x + … + c[N-1]·x^(N-1) on IEEE-754 single-precision samples using Horner's method.
- Shares one floating_point_mult_valid_only and one floating_point_add_valid_only instance, sequenced by an FSM.
- Successor to the fixed-tap polynomial estimator. Adds runtime-programmable coefficients with a write handshake, a channel tag that travels with each sample, a sample counter, and a defined latency for any core latency.
- Sits in the float DSP chain between the AXI-stream-style sample source and sink.

Parameters:
- G_NUM_COEFS, 6, number of coefficients N (polynomial order N-1); legal range 1..64.
- G_CHAN_WIDTH, 4, width of the channel tag carried with each sample; legal range 1..16.
- C_FP_DWIDTH, 32, localparam, float width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  0 = abort the current sample and hold idle; coefficients are retained.
- din  in  32  input sample x (float).
- din_chan  in  G_CHAN_WIDTH  channel tag of din.
- din_valid  in  1  input valid.
- din_ready  out  1  input ready.
- dout  out  32  result y (float).
- dout_chan  out  G_CHAN_WIDTH  tag of the sample that produced dout.
- dout_valid  out  1  output valid.
- dout_ready  in  1  output ready.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  clog2(max(N,2))  coefficient index k.
- coef_wr_data  in  32  coefficient value c[k].
- coef_wr_ready  out  1  1 = a write will be accepted this cycle.
- busy  out  1  1 while a sample is in flight (accept through dout handshake).
- sample_count  out  32  number of completed output handshakes; wraps from 0xFFFFFFFF to 0.

Behaviour:
- Reset (reset=1): every output is 0 (din_ready, dout, dout_chan, dout_valid, coef_wr_ready, busy, sample_count). All coefficients are cleared to 0x00000000. Core din_valid lines are 0. State goes to INIT.
- enable=0: the same as reset, except coefficients and sample_count are retained. An aborted sample never produces dout_valid.
- States are INIT, IDLE, MULT_ISSUE, MULT_WAIT, ADD_WAIT, SEND.
- INIT: on the next cycle, set din_ready=1 and coef_wr_ready=1, then go to IDLE.
- IDLE, coefficient write: a write occurs when coef_wr_en & coef_wr_ready. It sets c[coef_wr_addr] to coef_wr_data. An address ≥ N is ignored.
- IDLE, sample accept: an accept occurs when din_valid & din_ready. On accept:
  - capture x and the tag;
  - set acc to c[N-1] and k to N-2;
  - drop din_ready, coef_wr_ready and busy appropriately (busy goes to 1);
  - go to MULT_ISSUE, or go straight to SEND with dout=c[N-1] when N=1.
- Simultaneous write and accept in the same cycle: the write lands first, so the accepted sample uses the new coefficient.
- MULT_ISSUE: drive mult din1=acc and din2=x, pulse mult din_valid high for exactly 1 cycle, then go to MULT_WAIT.
- MULT_WAIT: on mult dout_valid, drive add din1=product and din2=c[k], pulse add din_valid for 1 cycle, then go to ADD_WAIT.
- ADD_WAIT: on add dout_valid, set acc to the sum.
  - If k=0: set dout=sum, dout_chan=tag, dout_valid=1, and go to SEND.
  - Otherwise: decrement k and go to MULT_ISSUE.
- SEND: dout, dout_chan and dout_valid are held stable until dout_ready.
  - On handshake: dout_valid=0, din_ready=1, coef_wr_ready=1, busy=0, sample_count+1, go to IDLE.
- Cores: each core returns exactly one dout_valid per din_valid pulse, after a fixed latency (Lm for the multiplier, La for the adder). Core din_valid is never high for more than 1 cycle. Each core has at most 1 operation outstanding.
- Latency: for an accept in cycle T, dout_valid first rises in cycle T+1+(N-1)·(Lm+La+3).
- Throughput: one sample per latency+1 cycles when dout_ready is held high.
- Arithmetic is whatever the cores produce (round-to-nearest-even). NaN and Inf propagate, with no special casing.
- din_ready is never high outside IDLE. coef_wr_ready equals din_ready.

Test Plan:
- N=3, write c=[1.0,2.0,3.0] (0x3F800000, 0x40000000, 0x40400000), then x=2.0, tag 5 -> dout=0x41880000 (17.0), dout_chan=5, at exactly T+1+2·(Lm+La+3), sample_count=1.
- N=3, same coefficients, back-to-back x=0.5 then x=-1.0 (0xBF800000), tags 1 and 2 -> 0x40300000 (2.75) then 0x40000000 (2.0), in order with matching tags, sample_count=2.
- N=1, c[0]=0x40400000, x=0x7F800000 -> dout=0x40400000 at T+1, and x is ignored.
- Hold dout_ready=0 for 10 cycles in SEND -> dout and dout_chan stable; din_ready=0 and coef_wr_ready=0; a write attempt to c[0] is ignored and the next result uses the old c[0].
- Assert reset mid-MULT_WAIT -> the next cycle has all outputs 0 and coefficients 0. The following x=2.0 yields 0x00000000, and there is no stale dout_valid.
- Drop enable mid-ADD_WAIT for 3 cycles -> no dout_valid for the aborted sample. Coefficients are retained: re-sending x=2.0 gives 0x41880000. A coef write with addr ≥ N has no effect.

Source files
------------

// File: rtl/floating_point_add_valid_only.sv
// Single-precision adder with a fixed-latency valid pipeline.
// Round-to-nearest-even; subnormal inputs/outputs flush to zero.
module floating_point_add_valid_only #(
    parameter int G_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic        din_valid,
    output logic [31:0] dout,
    output logic        dout_valid
);

    logic [31:0] w_sum;
    logic [31:0] r_data  [G_LATENCY];
    logic        r_valid [G_LATENCY];

    function automatic logic [31:0] f_fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]        ea;
        logic [7:0]        eb;
        logic [31:0]       big;
        logic [31:0]       sml;
        logic [7:0]        d;
        logic [47:0]       bm;
        logic [47:0]       sm;
        logic [47:0]       ssh;
        logic [48:0]       r;
        logic [48:0]       rn;
        int                pos;
        logic signed [9:0] e;
        logic [23:0]       m;
        logic [24:0]       mr;
        logic              g;
        logic              st;
        ea = a[30:23];
        eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 23'h0) || (eb == 8'hFF && b[22:0] != 23'h0)) begin
            return 32'h7FC0_0000;
        end
        if (ea == 8'hFF && eb == 8'hFF) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        if (ea == 8'hFF) return a;
        if (eb == 8'hFF) return b;
        if (ea == 8'h00 && eb == 8'h00) return {a[31] & b[31], 31'h0};
        if (ea == 8'h00) return b;
        if (eb == 8'h00) return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        bm = {1'b1, big[22:0], 24'h0};
        sm = {1'b1, sml[22:0], 24'h0};
        // Bits shifted out of the smaller operand are jammed into the LSB as sticky
        if (d >= 8'd48) begin
            ssh = 48'h1;
        end else begin
            ssh = sm >> d;
            if (d != 8'd0 && (sm << (8'd48 - d)) != 48'h0) ssh[0] = 1'b1;
        end
        if (big[31] == sml[31]) r = {1'b0, bm} + {1'b0, ssh};
        else                    r = {1'b0, bm} - {1'b0, ssh};
        if (r == 49'h0) return 32'h0;
        pos = 0;
        for (int i = 0; i < 49; i++) begin
            if (r[i]) pos = i;
        end
        rn = r << (48 - pos);
        e  = $signed({2'b00, big[30:23]}) + $signed(10'(pos)) - 10'sd47;
        m  = rn[48:25];
        g  = rn[24];
        st = |rn[23:0];
        mr = {1'b0, m} + {24'h0, g & (st | m[0])};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'sd1;
        end
        if (e >= 10'sd255) return {big[31], 8'hFF, 23'h0};
        if (e <= 10'sd0) return {big[31], 31'h0};
        return {big[31], e[7:0], mr[22:0]};
    endfunction

    assign w_sum = f_fp_add(din1, din2);

    // Delay result and valid by G_LATENCY cycles; only the valid line is reset.
    always_ff @(posedge clk) begin
        r_data[0]  <= w_sum;
        r_valid[0] <= reset ? 1'b0 : din_valid;
        for (int i = 1; i < G_LATENCY; i++) begin
            r_data[i]  <= r_data[i-1];
            r_valid[i] <= reset ? 1'b0 : r_valid[i-1];
        end
    end

    assign dout       = r_data[G_LATENCY-1];
    assign dout_valid = r_valid[G_LATENCY-1];

endmodule

// File: rtl/floating_point_mult_valid_only.sv
// Single-precision multiplier with a fixed-latency valid pipeline.
// Round-to-nearest-even; subnormal inputs/outputs flush to signed zero.
module floating_point_mult_valid_only #(
    parameter int G_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic        din_valid,
    output logic [31:0] dout,
    output logic        dout_valid
);

    logic [31:0] w_product;
    logic [31:0] r_data  [G_LATENCY];
    logic        r_valid [G_LATENCY];

    function automatic logic [31:0] f_fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [7:0]        ea;
        logic [7:0]        eb;
        logic [47:0]       p;
        logic [23:0]       m;
        logic [24:0]       mr;
        logic              g;
        logic              st;
        logic signed [9:0] e;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 23'h0) || (eb == 8'hFF && b[22:0] != 23'h0)) begin
            return 32'h7FC0_0000;
        end
        if (ea == 8'hFF || eb == 8'hFF) begin
            // inf * 0 is invalid
            if (ea == 8'h00 || eb == 8'h00) return 32'h7FC0_0000;
            return {s, 8'hFF, 23'h0};
        end
        if (ea == 8'h00 || eb == 8'h00) return {s, 31'h0};
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (p[47]) begin
            m  = p[47:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = p[46:23];
            g  = p[22];
            st = |p[21:0];
        end
        mr = {1'b0, m} + {24'h0, g & (st | m[0])};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'sd1;
        end
        if (e >= 10'sd255) return {s, 8'hFF, 23'h0};
        if (e <= 10'sd0) return {s, 31'h0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    assign w_product = f_fp_mul(din1, din2);

    // Delay result and valid by G_LATENCY cycles; only the valid line is reset.
    always_ff @(posedge clk) begin
        r_data[0]  <= w_product;
        r_valid[0] <= reset ? 1'b0 : din_valid;
        for (int i = 1; i < G_LATENCY; i++) begin
            r_data[i]  <= r_data[i-1];
            r_valid[i] <= reset ? 1'b0 : r_valid[i-1];
        end
    end

    assign dout       = r_data[G_LATENCY-1];
    assign dout_valid = r_valid[G_LATENCY-1];

endmodule

// File: rtl/horner_poly_evaluator.sv
// Horner-method polynomial evaluator: y = c[0] + c[1]*x + ... + c[N-1]*x^(N-1).
// One shared multiplier and adder, sequenced by an FSM; coefficients are
// runtime-writable while idle and each sample carries a channel tag.
module horner_poly_evaluator #(
    parameter int  G_NUM_COEFS  = 6,
    parameter int  G_CHAN_WIDTH = 4,
    localparam int C_FP_DWIDTH  = 32,
    localparam int C_ADDR_WIDTH = $clog2((G_NUM_COEFS > 2) ? G_NUM_COEFS : 2)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [C_FP_DWIDTH-1:0]  din,
    input  logic [G_CHAN_WIDTH-1:0] din_chan,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [C_FP_DWIDTH-1:0]  dout,
    output logic [G_CHAN_WIDTH-1:0] dout_chan,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    input  logic                    coef_wr_en,
    input  logic [C_ADDR_WIDTH-1:0] coef_wr_addr,
    input  logic [C_FP_DWIDTH-1:0]  coef_wr_data,
    output logic                    coef_wr_ready,
    output logic                    busy,
    output logic [31:0]             sample_count
);

    localparam int C_MULT_LATENCY = 3;
    localparam int C_ADD_LATENCY  = 2;
    localparam logic [C_ADDR_WIDTH-1:0] C_K_START =
        C_ADDR_WIDTH'((G_NUM_COEFS > 1) ? G_NUM_COEFS - 2 : 0);
    localparam logic [C_ADDR_WIDTH-1:0] C_TOP_ADDR = C_ADDR_WIDTH'(G_NUM_COEFS - 1);

    typedef enum logic [2:0] {
        StInit, StIdle, StMultIssue, StMultWait, StAddWait, StSend
    } state_e;

    state_e                  r_state;
    state_e                  w_state_next;

    logic [C_FP_DWIDTH-1:0]  r_coef [G_NUM_COEFS];
    logic [C_FP_DWIDTH-1:0]  r_x;
    logic [C_FP_DWIDTH-1:0]  r_acc;
    logic [C_FP_DWIDTH-1:0]  r_add_a;
    logic [C_FP_DWIDTH-1:0]  r_add_b;
    logic [C_FP_DWIDTH-1:0]  r_dout;
    logic [G_CHAN_WIDTH-1:0] r_tag;
    logic [G_CHAN_WIDTH-1:0] r_dout_chan;
    logic [C_ADDR_WIDTH-1:0] r_k;
    logic                    r_mult_valid;
    logic                    r_add_valid;
    logic [31:0]             r_sample_count;

    logic                    w_accept;
    logic                    w_coef_wr;
    logic [C_FP_DWIDTH-1:0]  w_top_coef;
    logic                    w_core_reset;
    logic [C_FP_DWIDTH-1:0]  w_mult_dout;
    logic                    w_mult_dout_valid;
    logic [C_FP_DWIDTH-1:0]  w_add_dout;
    logic                    w_add_dout_valid;

    assign w_accept  = din_valid & din_ready;
    assign w_coef_wr = coef_wr_en & coef_wr_ready & (int'(coef_wr_addr) < G_NUM_COEFS);
    // A write landing in the accept cycle must be seen by the new sample
    assign w_top_coef = (w_coef_wr && coef_wr_addr == C_TOP_ADDR) ? coef_wr_data
                                                                  : r_coef[G_NUM_COEFS-1];
    // Cores are flushed on abort so no stale result can leak into a later sample
    assign w_core_reset = reset | ~enable;

    assign dout         = r_dout;
    assign dout_chan    = r_dout_chan;
    assign sample_count = r_sample_count;

    floating_point_mult_valid_only #(
        .G_LATENCY (C_MULT_LATENCY)
    ) u_mult (
        .clk        (clk),
        .reset      (w_core_reset),
        .din1       (r_acc),
        .din2       (r_x),
        .din_valid  (r_mult_valid),
        .dout       (w_mult_dout),
        .dout_valid (w_mult_dout_valid)
    );

    floating_point_add_valid_only #(
        .G_LATENCY (C_ADD_LATENCY)
    ) u_add (
        .clk        (clk),
        .reset      (w_core_reset),
        .din1       (r_add_a),
        .din2       (r_add_b),
        .din_valid  (r_add_valid),
        .dout       (w_add_dout),
        .dout_valid (w_add_dout_valid)
    );

    // State register; reset and disable both return to INIT.
    always_ff @(posedge clk) begin
        if (reset || !enable) r_state <= StInit;
        else                  r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StInit:      w_state_next = StIdle;
            StIdle: begin
                if (w_accept) w_state_next = (G_NUM_COEFS == 1) ? StSend : StMultIssue;
            end
            StMultIssue: w_state_next = StMultWait;
            StMultWait: begin
                if (w_mult_dout_valid) w_state_next = StAddWait;
            end
            StAddWait: begin
                if (w_add_dout_valid) w_state_next = (r_k == '0) ? StSend : StMultIssue;
            end
            StSend: begin
                if (dout_ready) w_state_next = StIdle;
            end
            default:     w_state_next = StInit;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        din_ready     = 1'b0;
        dout_valid    = 1'b0;
        busy          = 1'b0;
        case (r_state)
            StIdle:                               din_ready = 1'b1;
            StMultIssue, StMultWait, StAddWait:   busy      = 1'b1;
            StSend: begin
                busy       = 1'b1;
                dout_valid = 1'b1;
            end
            default: ;
        endcase
        coef_wr_ready = din_ready;
    end

    // Datapath: coefficient store, Horner accumulator, core issue and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < G_NUM_COEFS; i++) r_coef[i] <= '0;
            r_sample_count <= '0;
            r_dout         <= '0;
            r_dout_chan    <= '0;
            r_mult_valid   <= 1'b0;
            r_add_valid    <= 1'b0;
        end else if (!enable) begin
            r_dout       <= '0;
            r_dout_chan  <= '0;
            r_mult_valid <= 1'b0;
            r_add_valid  <= 1'b0;
        end else begin
            if (w_coef_wr) r_coef[coef_wr_addr] <= coef_wr_data;

            r_mult_valid <= (r_state == StMultIssue);
            r_add_valid  <= (r_state == StMultWait) && w_mult_dout_valid;

            if (w_accept) begin
                r_x   <= din;
                r_tag <= din_chan;
                r_acc <= w_top_coef;
                r_k   <= C_K_START;
                if (G_NUM_COEFS == 1) begin
                    r_dout      <= w_top_coef;
                    r_dout_chan <= din_chan;
                end
            end

            if (r_state == StMultWait && w_mult_dout_valid) begin
                r_add_a <= w_mult_dout;
                r_add_b <= r_coef[r_k];
            end

            if (r_state == StAddWait && w_add_dout_valid) begin
                r_acc <= w_add_dout;
                if (r_k == '0) begin
                    r_dout      <= w_add_dout;
                    r_dout_chan <= r_tag;
                end else begin
                    r_k <= r_k - 1'b1;
                end
            end

            if (r_state == StSend && dout_ready) r_sample_count <= r_sample_count + 32'd1;
        end
    end

endmodule
